// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sb_pkg
//  Description : Shared constants, the config-entry type and the routing map
//                of the configurable switch box.
//  Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;

    // Source-select codes. Codes 0..2 pick one of the three other sides;
    // codes starting at SRC_PE_BASE pick PE outputs.
    localparam int SRC_SIDE_0  = 0;
    localparam int SRC_SIDE_1  = 1;
    localparam int SRC_SIDE_2  = 2;
    localparam int SRC_PE_BASE = 3;

    // The stored select field is kept at a fixed width so one entry type
    // serves every NUM_PE (up to 253 PE sources); unused high bits stay zero.
    localparam int SB_SEL_MAX_W = 8;

    typedef struct packed {
        logic                    reg_mode;
        logic [SB_SEL_MAX_W-1:0] sel;
    } sb_cfg_t;

    // Side that feeds output side s when track-select code k is chosen.
    function automatic int sb_src_side(input int s, input int k);
        return (s + 1 + k) % 4;
    endfunction

    // Track on that source side; the offset rotates so the three choices of
    // one output land on different tracks.
    function automatic int sb_src_track(input int s, input int t, input int k,
                                        input int tracks);
        return (t + sb_src_side(s, k) + 3) % tracks;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_out_mux.sv
`default_nettype none
// ============================================================================
//  Module      : sb_out_mux
//  Description : Source multiplexer for one switch-box output, with a
//                per-output choice of combinational or registered drive.
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_out_mux
    import sb_pkg::*;
#(
    parameter int TRACKS = 4,
    parameter int WIDTH  = 1,
    parameter int NUM_PE = 1,
    parameter int SIDE   = 0,
    parameter int TRACK  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*TRACKS*WIDTH-1:0] i_in_wire,
    input  logic [NUM_PE*WIDTH-1:0]   i_pe_in,
    input  sb_cfg_t                   i_cfg,
    output logic [WIDTH-1:0]          o_out
);

    // Bit offsets of the three track sources this output can reach.
    localparam int c_SLOT_0 = (sb_src_side(SIDE, SRC_SIDE_0) * TRACKS
                              + sb_src_track(SIDE, TRACK, SRC_SIDE_0, TRACKS)) * WIDTH;
    localparam int c_SLOT_1 = (sb_src_side(SIDE, SRC_SIDE_1) * TRACKS
                              + sb_src_track(SIDE, TRACK, SRC_SIDE_1, TRACKS)) * WIDTH;
    localparam int c_SLOT_2 = (sb_src_side(SIDE, SRC_SIDE_2) * TRACKS
                              + sb_src_track(SIDE, TRACK, SRC_SIDE_2, TRACKS)) * WIDTH;

    logic [WIDTH-1:0]          w_mux;
    logic [WIDTH-1:0]          r_out;
    logic [4*TRACKS*WIDTH-1:0] w_unused_in;

    // Only three track slots feed this output; the rest of the bus is dropped.
    assign w_unused_in = i_in_wire;

    // Select the source; codes beyond the last PE drive zeros.
    always_comb begin
        w_mux = '0;
        if (i_cfg.sel == SB_SEL_MAX_W'(SRC_SIDE_0)) begin
            w_mux = i_in_wire[c_SLOT_0 +: WIDTH];
        end else if (i_cfg.sel == SB_SEL_MAX_W'(SRC_SIDE_1)) begin
            w_mux = i_in_wire[c_SLOT_1 +: WIDTH];
        end else if (i_cfg.sel == SB_SEL_MAX_W'(SRC_SIDE_2)) begin
            w_mux = i_in_wire[c_SLOT_2 +: WIDTH];
        end else begin
            for (int p = 0; p < NUM_PE; p++) begin
                if (i_cfg.sel == SB_SEL_MAX_W'(SRC_PE_BASE + p)) begin
                    w_mux = i_pe_in[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Pipeline stage loads every cycle so a mode switch never shows stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            r_out <= w_mux;
        end
    end

    assign o_out = i_cfg.reg_mode ? r_out : w_mux;

endmodule
`default_nettype wire

// File: rtl/switch_box_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_box_cfg
//  Description : Parametrised 4-side switch box with shadow/active config
//                stores, addressed write/readback and a single commit strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_box_cfg
    import sb_pkg::*;
#(
    parameter  int TRACKS = 4,
    parameter  int WIDTH  = 1,
    parameter  int NUM_PE = 1,
    localparam int SEL_W  = $clog2(3 + NUM_PE),
    localparam int ADDR_W = $clog2(4 * TRACKS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*TRACKS*WIDTH-1:0] in_wire,
    output logic [4*TRACKS*WIDTH-1:0] out_wire,
    input  logic [NUM_PE*WIDTH-1:0]   pe_in,
    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [SEL_W:0]            cfg_wdata,
    input  logic                      cfg_we,
    input  logic                      cfg_re,
    output logic [SEL_W:0]            cfg_rdata,
    output logic                      cfg_rvalid,
    input  logic                      cfg_commit
);

    localparam int c_NOUT = 4 * TRACKS;

    sb_cfg_t        r_shadow [c_NOUT];
    sb_cfg_t        r_active [c_NOUT];
    sb_cfg_t        w_wentry;
    logic           w_addr_ok;
    logic [SEL_W:0] w_rd_data;
    logic [SEL_W:0] r_rdata;
    logic           r_rvalid;

    // When the store fills the address space every address is a real entry.
    if (c_NOUT == 2**ADDR_W) begin : g_addr_full
        assign w_addr_ok = 1'b1;
    end else begin : g_addr_partial
        assign w_addr_ok = (cfg_addr < ADDR_W'(c_NOUT));
    end

    // Widen the written word into a stored entry.
    always_comb begin
        w_wentry          = '0;
        w_wentry.reg_mode = cfg_wdata[SEL_W];
        w_wentry.sel      = SB_SEL_MAX_W'(cfg_wdata[SEL_W-1:0]);
    end

    // Readback value: same-cycle write wins; out-of-range reads return zero.
    always_comb begin
        w_rd_data = '0;
        if (w_addr_ok) begin
            if (cfg_we) begin
                w_rd_data = cfg_wdata;
            end else begin
                w_rd_data = {r_shadow[cfg_addr].reg_mode,
                             r_shadow[cfg_addr].sel[SEL_W-1:0]};
            end
        end
    end

    // Shadow writes, and commit copying the (post-write) shadow into active.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NOUT; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (cfg_we && w_addr_ok) begin
                r_shadow[cfg_addr] <= w_wentry;
            end
            if (cfg_commit) begin
                for (int i = 0; i < c_NOUT; i++) begin
                    r_active[i] <= (cfg_we && w_addr_ok && cfg_addr == ADDR_W'(i))
                                   ? w_wentry : r_shadow[i];
                end
            end
        end
    end

    // Readback register; data holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= cfg_re;
            if (cfg_re) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    assign cfg_rdata  = r_rdata;
    assign cfg_rvalid = r_rvalid;

    for (genvar gi = 0; gi < c_NOUT; gi++) begin : g_out
        sb_out_mux #(
            .TRACKS (TRACKS),
            .WIDTH  (WIDTH),
            .NUM_PE (NUM_PE),
            .SIDE   (gi / TRACKS),
            .TRACK  (gi % TRACKS)
        ) u_mux (
            .clk       (clk),
            .reset     (reset),
            .i_in_wire (in_wire),
            .i_pe_in   (pe_in),
            .i_cfg     (r_active[gi]),
            .o_out     (out_wire[gi*WIDTH +: WIDTH])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_box_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_box_cfg
//  Description : Scoreboard bench for switch_box_cfg against a behavioural
//                model of routing, config stores and readback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_box_cfg;

    localparam int TRACKS = 4;
    localparam int WIDTH  = 2;
    localparam int NUM_PE = 2;
    localparam int SEL_W  = 3;        // $clog2(3+2)
    localparam int ADDR_W = 4;        // $clog2(16)
    localparam int NOUT   = 4 * TRACKS;
    localparam int NW     = NOUT * WIDTH;
    localparam int CW     = SEL_W + 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NW-1:0]           in_w;
    logic [NW-1:0]           out_wire;
    logic [NUM_PE*WIDTH-1:0] pe;
    logic [ADDR_W-1:0]       addr;
    logic [CW-1:0]           wdata;
    logic                    we, re, commit;
    logic [CW-1:0]           cfg_rdata;
    logic                    cfg_rvalid;

    always #5 clk = ~clk;

    switch_box_cfg #(.TRACKS(TRACKS), .WIDTH(WIDTH), .NUM_PE(NUM_PE)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_wire    (in_w),
        .out_wire   (out_wire),
        .pe_in      (pe),
        .cfg_addr   (addr),
        .cfg_wdata  (wdata),
        .cfg_we     (we),
        .cfg_re     (re),
        .cfg_rdata  (cfg_rdata),
        .cfg_rvalid (cfg_rvalid),
        .cfg_commit (commit)
    );

    // Reference state: plain arrays of {reg_mode, sel} words.
    logic [CW-1:0]    m_shadow [NOUT];
    logic [CW-1:0]    m_active [NOUT];
    logic [WIDTH-1:0] m_outreg [NOUT];
    logic [CW-1:0]    m_rdata;
    logic             m_rvalid;

    typedef struct {
        logic [NW-1:0] out;
        logic          rv;
        logic [CW-1:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   checking = 0;

    // Value seen by output (s,t) for select code k with the current inputs.
    function automatic logic [WIDTH-1:0] route(int s, int t, int k);
        int q, tr;
        if (k < 3) begin
            q  = (s + 1 + k) % 4;
            tr = (t + q + 3) % TRACKS;
            return in_w[(q*TRACKS + tr)*WIDTH +: WIDTH];
        end
        if (k < 3 + NUM_PE) return pe[(k-3)*WIDTH +: WIDTH];
        return '0;
    endfunction

    // One clock: queue what the DUT must show this cycle, then advance model.
    task automatic step();
        exp_t e;
        int   k;
        for (int i = 0; i < NOUT; i++) begin
            k = int'(m_active[i][SEL_W-1:0]);
            e.out[i*WIDTH +: WIDTH] = m_active[i][SEL_W] ? m_outreg[i]
                                                         : route(i / TRACKS, i % TRACKS, k);
        end
        e.rv = m_rvalid;
        e.rd = m_rdata;
        if (checking) sb_q.push_back(e);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NOUT; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
                m_outreg[i] = '0;
            end
            m_rdata  = '0;
            m_rvalid = 1'b0;
        end else begin
            for (int i = 0; i < NOUT; i++)
                m_outreg[i] = route(i / TRACKS, i % TRACKS, int'(m_active[i][SEL_W-1:0]));
            if (we && int'(addr) < NOUT) m_shadow[addr] = wdata;
            if (commit) for (int i = 0; i < NOUT; i++) m_active[i] = m_shadow[i];
            m_rvalid = re;
            if (re) m_rdata = (int'(addr) < NOUT) ? m_shadow[addr] : '0;
        end
        #1;
    endtask

    task automatic set_in(int s, int t, logic [WIDTH-1:0] v);
        in_w[(s*TRACKS + t)*WIDTH +: WIDTH] = v;
    endtask

    task automatic idle();
        we = 0; re = 0; commit = 0;
    endtask

    // Monitor: outputs are present every cycle, so one entry per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (out_wire !== e.out) begin
                failures++;
                $display("FAIL out_wire t=%0t got=%h exp=%h", $time, out_wire, e.out);
            end
            checks++;
            if (cfg_rvalid !== e.rv) begin
                failures++;
                $display("FAIL cfg_rvalid t=%0t got=%b exp=%b", $time, cfg_rvalid, e.rv);
            end
            checks++;
            if (cfg_rdata !== e.rd) begin
                failures++;
                $display("FAIL cfg_rdata t=%0t got=%h exp=%h", $time, cfg_rdata, e.rd);
            end
        end
    end

    initial begin
        reset = 1; in_w = '0; pe = '0; addr = '0; wdata = '0; idle();
        step();                         // DUT state unknown before first edge
        checking = 1;
        step();                         // reset state, reset still high
        reset = 0;

        // Default routing: out(0,0) follows in(1,0) combinationally.
        set_in(1, 0, 2'b01); step();
        set_in(1, 0, 2'b10); step();

        // Uncommitted write must not change routing; commit then does.
        addr = 0; wdata = 4'b0001; we = 1; step(); idle();
        set_in(2, 1, 2'b11); step();
        set_in(1, 0, 2'b00); step();
        commit = 1; step(); idle();
        set_in(2, 1, 2'b01); step();
        re = 1; addr = 0; step(); idle(); step();

        // Registered PE source on out(1,1).
        addr = 5; wdata = 4'b1011; we = 1; step(); idle();
        commit = 1; step(); idle();
        pe[1:0] = 2'b00; step();
        pe[1:0] = 2'b11; step();
        pe[1:0] = 2'b00; step(); step();

        // Write and commit in the same cycle: write-through to active.
        addr = 2; wdata = 4'b0010; we = 1; commit = 1; set_in(3, 0, 2'b11); step(); idle();
        step(); set_in(3, 0, 2'b01); step();
        commit = 1; step(); commit = 1; step(); idle();   // back-to-back commits

        // Select code past the last PE drives zeros. With TRACKS=4 the 4-bit
        // address covers exactly 16 entries, so no out-of-range address exists.
        addr = 3; wdata = 4'b0111; we = 1; commit = 1; step(); idle();
        for (int n = 0; n < 4; n++) begin
            in_w = NW'($urandom); pe = (NUM_PE*WIDTH)'($urandom); step();
        end

        // Full config, new shadow values, then reset discards everything.
        for (int i = 0; i < NOUT; i++) begin
            addr = ADDR_W'(i); wdata = CW'($urandom); we = 1;
            in_w = NW'($urandom); step();
        end
        idle(); commit = 1; step(); idle();
        for (int i = 0; i < NOUT; i++) begin
            addr = ADDR_W'(i); wdata = CW'($urandom); we = 1; re = 1;
            in_w = NW'($urandom); pe = (NUM_PE*WIDTH)'($urandom); step();
        end
        idle(); re = 1; reset = 1; step(); reset = 0; idle(); step();
        for (int i = 0; i < NOUT; i++) begin
            addr = ADDR_W'(i); re = 1; in_w = NW'($urandom); step();
        end
        idle(); step();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            in_w   = NW'($urandom);
            pe     = (NUM_PE*WIDTH)'($urandom);
            addr   = ADDR_W'($urandom_range(0, NOUT - 1));
            wdata  = CW'($urandom);
            we     = ($urandom_range(0, 9) < 3);
            re     = ($urandom_range(0, 9) < 3);
            commit = ($urandom_range(0, 19) < 3);
            reset  = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 0; idle(); step();

        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
